// File: rtl/coord_packet_tx_scheduler_if.sv
// Coordinate snapshot inputs, UART start/busy handshake and status outputs of the packet scheduler.
// The slave side is the scheduler; the master side is the tracker/transmitter environment.
interface coord_packet_tx_scheduler_if;
  logic        update_in;
  logic [11:0] x_top_in;
  logic [11:0] y_top_in;
  logic [11:0] x_bot_in;
  logic [11:0] y_bot_in;
  logic        tx_busy_in;
  logic        tx_start_out;
  logic [7:0]  tx_data_out;
  logic        active_out;
  logic        packet_done_out;
  logic [15:0] packets_sent_out;
  logic [15:0] updates_dropped_out;

  modport master (
    output update_in, x_top_in, y_top_in, x_bot_in, y_bot_in, tx_busy_in,
    input  tx_start_out, tx_data_out, active_out, packet_done_out,
           packets_sent_out, updates_dropped_out
  );

  modport slave (
    input  update_in, x_top_in, y_top_in, x_bot_in, y_bot_in, tx_busy_in,
    output tx_start_out, tx_data_out, active_out, packet_done_out,
           packets_sent_out, updates_dropped_out
  );
endinterface

// File: rtl/coord_packet_tx_scheduler.sv
// Frames clamped hand-coordinate snapshots into 9-byte FF-FF-FF-led UART packets with periodic resend.
// First tx_start two cycles after update_in from idle; each byte waits on tx_busy, then a fixed gap.
module coord_packet_tx_scheduler #(
  parameter int unsigned CLK_HZ         = 65_000_000,
  parameter int unsigned REFRESH_CYCLES = 2_166_666,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned ARM_CYCLES     = 2
) (
  input logic                        clk_in,
  input logic                        rst_in,
  coord_packet_tx_scheduler_if.slave bus
);

  if (CLK_HZ == 0) begin : g_clk_hz_check
    $error("CLK_HZ must be non-zero");
  end

  typedef enum logic [2:0] {IDLE, LOAD, START, ARM, WAIT, GAP} state_t;

  state_t      state_q, state_d;
  logic [47:0] snap_q, pend_q;
  logic        pend_vld_q, have_snap_q;
  logic [3:0]  idx_q;
  logic [31:0] cnt_q, rfr_q;
  logic [7:0]  tx_data_q;
  logic        active_q, done_q, start_c, refresh_due;
  logic [15:0] sent_q, dropped_q;

  function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Snapshot packs {xt, yt, xb, yb}, so payload bytes are consecutive 8-bit slices.
  function automatic logic [7:0] pkt_byte(input logic [47:0] s, input logic [3:0] i);
    case (i)
      4'd3:    return s[47:40];
      4'd4:    return s[39:32];
      4'd5:    return s[31:24];
      4'd6:    return s[23:16];
      4'd7:    return s[15:8];
      4'd8:    return s[7:0];
      default: return 8'hFF;
    endcase
  endfunction

  assign refresh_due = (REFRESH_CYCLES != 0) && have_snap_q && (rfr_q == 32'd1);

  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    case (state_q)
      IDLE:    if (pend_vld_q || bus.update_in || refresh_due) state_d = LOAD;
      LOAD:    state_d = START;
      START: begin
        start_c = 1'b1;
        state_d = ARM;
      end
      ARM:     if (cnt_q + 32'd1 >= ARM_CYCLES) state_d = WAIT;
      WAIT:    if (!bus.tx_busy_in) state_d = (idx_q == 4'd8) ? IDLE : GAP;
      GAP:     if (cnt_q + 32'd1 >= GAP_CYCLES) state_d = START;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      have_snap_q <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      rfr_q       <= REFRESH_CYCLES;
      tx_data_q   <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      sent_q      <= '0;
      dropped_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;

      // An update consumed by LOAD in the same cycle is not a drop; any other overwrite is.
      if (bus.update_in) begin
        pend_q      <= {clamp(bus.x_top_in, 12'd1023), clamp(bus.y_top_in, 12'd767),
                        clamp(bus.x_bot_in, 12'd1023), clamp(bus.y_bot_in, 12'd767)};
        pend_vld_q  <= 1'b1;
        have_snap_q <= 1'b1;
        if (pend_vld_q && state_q != LOAD && dropped_q != 16'hFFFF)
          dropped_q <= dropped_q + 16'd1;
      end else if (state_q == LOAD) begin
        pend_vld_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (state_d == LOAD)     rfr_q <= REFRESH_CYCLES;
          else if (rfr_q > 32'd1)  rfr_q <= rfr_q - 32'd1;
        end
        LOAD: begin
          if (pend_vld_q) snap_q <= pend_q;
          idx_q     <= '0;
          active_q  <= 1'b1;
          tx_data_q <= 8'hFF;
        end
        START: cnt_q <= '0;
        ARM:   cnt_q <= cnt_q + 32'd1;
        WAIT: begin
          cnt_q <= '0;
          if (!bus.tx_busy_in && idx_q == 4'd8) begin
            done_q   <= 1'b1;
            sent_q   <= sent_q + 16'd1;
            active_q <= 1'b0;
            rfr_q    <= REFRESH_CYCLES;
          end
        end
        GAP: begin
          cnt_q <= cnt_q + 32'd1;
          if (state_d == START) begin
            idx_q     <= idx_q + 4'd1;
            tx_data_q <= pkt_byte(snap_q, idx_q + 4'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_start_out        = start_c;
  assign bus.tx_data_out         = tx_data_q;
  assign bus.active_out          = active_q;
  assign bus.packet_done_out     = done_q;
  assign bus.packets_sent_out    = sent_q;
  assign bus.updates_dropped_out = dropped_q;

endmodule

// File: tb/tb_coord_packet_tx_scheduler.sv
// Scoreboard bench for coord_packet_tx_scheduler with a 10-cycle-busy transmitter model.
module tb_coord_packet_tx_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coord_packet_tx_scheduler_if sif();

  coord_packet_tx_scheduler #(
    .CLK_HZ(65_000_000), .REFRESH_CYCLES(50), .GAP_CYCLES(16), .ARM_CYCLES(2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus(sif.slave)
  );

  int compared = 0;
  int errors   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [47:0] vin  [5];
  logic [71:0] vexp [5];
  logic [7:0]  exp_q [$];

  int n_start = 0, n_done = 0, pos = 0, busy_left = 0;
  int pkt_start_cyc = 0, last_done_cyc = 0, upd_cyc = 0;
  logic [23:0] hist = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit expect_it);
    logic [47:0] w;
    logic [71:0] e;
    w = vin[v];
    e = vexp[v];
    sif.x_top_in = w[47:36];
    sif.y_top_in = w[35:24];
    sif.x_bot_in = w[23:12];
    sif.y_bot_in = w[11:0];
    sif.update_in = 1'b1;
    upd_cyc = cyc;
    if (expect_it)
      for (int i = 0; i < 9; i++) exp_q.push_back(e[71 - 8*i -: 8]);
    tick();
    sif.update_in = 1'b0;
  endtask

  task automatic push_pkt(input int v);
    logic [71:0] e;
    e = vexp[v];
    for (int i = 0; i < 9; i++) exp_q.push_back(e[71 - 8*i -: 8]);
  endtask

  task automatic wait_done(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (n_done < n && k < budget) begin
      tick();
      k++;
    end
    chk(nm, n_done, n);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_start"},   {31'd0, sif.tx_start_out}, 0);
    chk({nm, "_data"},    {24'd0, sif.tx_data_out}, 0);
    chk({nm, "_active"},  {31'd0, sif.active_out}, 0);
    chk({nm, "_done"},    {31'd0, sif.packet_done_out}, 0);
    chk({nm, "_sent"},    {16'd0, sif.packets_sent_out}, 0);
    chk({nm, "_dropped"}, {16'd0, sif.updates_dropped_out}, 0);
  endtask

  // Transmitter model: busy for 10 cycles after each start.
  initial begin
    sif.tx_busy_in = 1'b0;
    forever begin
      @(negedge clk);
      if (sif.tx_start_out === 1'b1) busy_left = 10;
      else if (busy_left > 0)        busy_left--;
      sif.tx_busy_in = (busy_left != 0);
    end
  end

  // Monitor: pops the scoreboard on every tx_start.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pos = 0;
      end else begin
        if (sif.tx_start_out === 1'b1) begin
          n_start++;
          if (pos == 0) pkt_start_cyc = cyc;
          compared++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tx_start: got byte %02h expected no start", sif.tx_data_out);
          end else begin
            b = exp_q.pop_front();
            if (sif.tx_data_out !== b) begin
              errors++;
              $display("FAIL byte%0d: got %02h expected %02h", pos, sif.tx_data_out, b);
            end
          end
          chk("active_in_flight", {31'd0, sif.active_out}, 1);
          hist = {hist[15:0], sif.tx_data_out};
          if (pos >= 3) begin
            compared++;
            if (hist == 24'hFFFFFF) begin
              errors++;
              $display("FAIL payload_sync_run at byte %0d: got %06h expected not FFFFFF", pos, hist);
            end
          end
          pos++;
        end
        if (sif.packet_done_out === 1'b1) begin
          n_done++;
          last_done_cyc = cyc;
          pos = 0;
          chk("active_after_done", {31'd0, sif.active_out}, 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, p;
    vin[0] = {12'h123, 12'h0AB, 12'h045, 12'h2FF}; vexp[0] = 72'hFFFFFF_12_30AB_04_52FF;
    vin[1] = {12'hFFF, 12'h900, 12'h800, 12'hFFF}; vexp[1] = 72'hFFFFFF_3F_F2FF_3F_F2FF;
    vin[2] = {12'h3FF, 12'h300, 12'h400, 12'h001}; vexp[2] = 72'hFFFFFF_3F_F2FF_3F_F001;
    vin[3] = {12'h001, 12'h002, 12'h003, 12'h004}; vexp[3] = 72'hFFFFFF_00_1002_00_3004;
    vin[4] = {12'h2A5, 12'h1C3, 12'h0F0, 12'h10E}; vexp[4] = 72'hFFFFFF_2A_51C3_0F_010E;
    sif.update_in = 1'b0;
    sif.x_top_in = '0; sif.y_top_in = '0; sif.x_bot_in = '0; sif.y_bot_in = '0;

    rst_n = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    s = n_start;
    repeat (100) tick();
    chk("no_start_without_snapshot", n_start - s, 0);

    // Nominal packet and first-start latency.
    send(0, 1'b1);
    wait_done(1, 400, "done_pkt1");
    chk("first_start_latency", pkt_start_cyc - upd_cyc, 2);
    chk("sent_after_pkt1", {16'd0, sif.packets_sent_out}, 1);
    chk("done_is_pulse", {31'd0, sif.packet_done_out}, 0);
    chk("queue_drained_pkt1", exp_q.size(), 0);

    // Clamped coordinates.
    send(1, 1'b1);
    wait_done(2, 400, "done_clamp");
    chk("sent_after_clamp", {16'd0, sif.packets_sent_out}, 2);

    // Three updates during one packet: middle one is overwritten.
    send(2, 1'b1);
    repeat (4) tick();
    send(3, 1'b0);
    repeat (4) tick();
    send(4, 1'b1);
    wait_done(4, 800, "done_three_updates");
    chk("dropped_one", {16'd0, sif.updates_dropped_out}, 1);
    chk("sent_after_three", {16'd0, sif.packets_sent_out}, 4);
    chk("queue_drained_three", exp_q.size(), 0);

    // Refresh: same packet after 50 idle cycles, then LOAD, then START.
    p = last_done_cyc;
    push_pkt(4);
    wait_done(5, 500, "done_refresh");
    chk("refresh_start_delay", pkt_start_cyc - p, 51);

    // Update coinciding with refresh expiry carries the new data.
    p = last_done_cyc;
    while (cyc < p + 49) tick();
    send(0, 1'b1);
    wait_done(6, 400, "done_coincide");
    chk("coincide_start_latency", pkt_start_cyc - upd_cyc, 2);
    chk("sent_after_coincide", {16'd0, sif.packets_sent_out}, 6);
    chk("queue_drained_coincide", exp_q.size(), 0);

    // Reset while byte 4 is waiting on busy.
    s = n_start;
    send(1, 1'b1);
    begin
      int k;
      k = 0;
      while (n_start < s + 5 && k < 400) begin
        tick();
        k++;
      end
    end
    chk("reached_byte4", n_start - s, 5);
    repeat (4) tick();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    chk_all_zero("midpkt_reset");
    rst_n = 1'b1;
    s = n_start;
    repeat (100) tick();
    chk("no_start_after_reset", n_start - s, 0);
    chk("sent_zero_after_reset", {16'd0, sif.packets_sent_out}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end
endmodule
